// File: rtl/fifo_n.sv
// Parametrised-depth ready/valid FIFO with synchronous flush (same-cycle refill),
// occupancy count, almost-full watermark and selectable ready pass-through.
module fifo_n #(
  parameter type         T          = logic [31:0],
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned AF_LEVEL   = DEPTH - 1,
  parameter bit          READY_PASS = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush_in,
  input  logic                       valid_in,
  output logic                       ready_in,
  input  T                           data_in,
  output logic                       valid_out,
  input  logic                       ready_out,
  output T                           data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH+1)-1:0] count_out
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;

  // Status flags come only from the count register.
  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= CNT_W'(AF_LEVEL));
  assign count_out   = count_q;
  assign valid_out   = !empty;
  assign data_out    = mem_q[rptr_q];

  // Pass-through mode lets a same-cycle pop free a slot for a full FIFO.
  assign ready_in = flush_in || !full || (READY_PASS && ready_out);
  assign push     = valid_in && ready_in;
  assign pop      = valid_out && ready_out;

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = wptr_q;
    if (flush_in) begin
      rptr_d  = '0;
      wr_idx  = '0;
      wr_en   = valid_in;
      wptr_d  = valid_in ? PTR_W'(1) : '0;
      count_d = valid_in ? CNT_W'(1) : '0;
    end else begin
      if (push) begin
        wr_en  = 1'b1;
        wptr_d = wptr_q + PTR_W'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= data_in;
    end
  end

endmodule

// File: tb/tb_fifo_n.sv
// Directed bench for fifo_n: two instances (READY_PASS=0 and 1) share one stimulus.
module tb_fifo_n;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush_in;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] data_in;

  logic        r0_ready, r0_valid, r0_full, r0_empty, r0_af;
  logic [31:0] r0_data;
  logic [2:0]  r0_count;
  logic        r1_ready, r1_valid, r1_full, r1_empty, r1_af;
  logic [31:0] r1_data;
  logic [2:0]  r1_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fifo_n #(.DEPTH(4), .READY_PASS(1'b0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .flush_in(flush_in),
    .valid_in(valid_in), .ready_in(r0_ready), .data_in(data_in),
    .valid_out(r0_valid), .ready_out(ready_out), .data_out(r0_data),
    .full(r0_full), .empty(r0_empty), .almost_full(r0_af), .count_out(r0_count)
  );

  fifo_n #(.DEPTH(4), .READY_PASS(1'b1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .flush_in(flush_in),
    .valid_in(valid_in), .ready_in(r1_ready), .data_in(data_in),
    .valid_out(r1_valid), .ready_out(ready_out), .data_out(r1_data),
    .full(r1_full), .empty(r1_empty), .almost_full(r1_af), .count_out(r1_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " r0 count"}, 32'(r0_count), 32'd0);
    chk({tag, " r0 valid"}, 32'(r0_valid), 32'd0);
    chk({tag, " r0 ready"}, 32'(r0_ready), 32'd1);
    chk({tag, " r0 full"},  32'(r0_full),  32'd0);
    chk({tag, " r0 empty"}, 32'(r0_empty), 32'd1);
    chk({tag, " r0 af"},    32'(r0_af),    32'd0);
    chk({tag, " r1 count"}, 32'(r1_count), 32'd0);
    chk({tag, " r1 valid"}, 32'(r1_valid), 32'd0);
    chk({tag, " r1 ready"}, 32'(r1_ready), 32'd1);
  endtask

  task automatic push_beats(input logic [31:0] base, input int n);
    ready_out = 1'b0;
    valid_in  = 1'b1;
    for (int i = 0; i < n; i++) begin
      data_in = base + 32'(i);
      step();
    end
    valid_in = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; flush_in = 1'b0; valid_in = 1'b0; ready_out = 1'b0; data_in = '0;
    #1;
    chk_idle("reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Asynchronous reset in the middle of a burst
    push_beats(32'h1, 3);
    chk("pre-reset count", 32'(r0_count), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    chk_idle("async reset");
    #1 reset_n = 1'b1;
    step();
    chk_idle("post reset");

    // Fill and drain ordering
    ready_out = 1'b0;
    valid_in  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = 32'hA0 + 32'(i);
      step();
      if (i == 2) begin
        chk("af at 3", 32'(r0_af), 32'd1);
        chk("not full at 3", 32'(r0_full), 32'd0);
      end
    end
    chk("full r0", 32'(r0_full), 32'd1);
    chk("full r1", 32'(r1_full), 32'd1);
    chk("full count", 32'(r0_count), 32'd4);
    chk("full ready r0", 32'(r0_ready), 32'd0);
    chk("full ready r1 no pop", 32'(r1_ready), 32'd0);
    valid_in  = 1'b0;
    ready_out = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain data r0", r0_data, 32'hA0 + 32'(i));
      chk("drain data r1", r1_data, 32'hA0 + 32'(i));
      step();
    end
    chk("drained empty", 32'(r0_empty), 32'd1);
    chk("drained valid", 32'(r0_valid), 32'd0);

    // Streaming across pointer wrap at occupancy 2
    push_beats(32'h0, 2);
    valid_in  = 1'b1;
    ready_out = 1'b1;
    for (int i = 2; i < 10; i++) begin
      data_in = 32'(i);
      #1;
      chk("stream ready", 32'(r0_ready), 32'd1);
      chk("stream data", r0_data, 32'(i - 2));
      step();
      chk("stream count", 32'(r0_count), 32'd2);
    end
    valid_in = 1'b0;
    for (int i = 8; i < 10; i++) begin
      chk("stream tail", r0_data, 32'(i));
      step();
    end
    chk("stream empty", 32'(r0_empty), 32'd1);

    // Full plus same-cycle pop
    push_beats(32'hB0, 4);
    valid_in  = 1'b1;
    data_in   = 32'hB4;
    ready_out = 1'b1;
    #1;
    chk("fpp ready r0", 32'(r0_ready), 32'd0);
    chk("fpp ready r1", 32'(r1_ready), 32'd1);
    step();
    valid_in = 1'b0;
    chk("fpp count r0", 32'(r0_count), 32'd3);
    chk("fpp count r1", 32'(r1_count), 32'd4);
    for (int i = 1; i < 5; i++) begin
      chk("fpp drain r1", r1_data, 32'hB0 + 32'(i));
      if (i < 4) chk("fpp drain r0", r0_data, 32'hB0 + 32'(i));
      else       chk("fpp r0 empty", 32'(r0_valid), 32'd0);
      step();
    end
    chk("fpp r1 empty", 32'(r1_empty), 32'd1);

    // Flush with same-cycle refill; the popped head is void
    ready_out = 1'b0;
    valid_in  = 1'b1;
    data_in = 32'h11; step();
    data_in = 32'h22; step();
    data_in = 32'h33; step();
    flush_in  = 1'b1;
    data_in   = 32'h99;
    ready_out = 1'b1;
    step();
    flush_in = 1'b0;
    valid_in = 1'b0;
    chk("refill count", 32'(r0_count), 32'd1);
    chk("refill data", r0_data, 32'h99);
    chk("refill valid", 32'(r0_valid), 32'd1);
    chk("refill data r1", r1_data, 32'h99);
    step();
    chk("refill then empty", 32'(r0_empty), 32'd1);

    // Flush without refill from full
    push_beats(32'hC0, 4);
    flush_in = 1'b1;
    #1;
    chk("flush ready full", 32'(r0_ready), 32'd1);
    step();
    flush_in = 1'b0;
    chk_idle("flush empty");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_n.md
# fifo_n

Parametrised-depth ready/valid FIFO with flush. It is the general successor to the two-entry decoupling FIFO between fetch and decode, and is used wherever a pipeline boundary needs more than two beats of slack (fetch queue, decode-to-issue, LSU response queue). It adds depth/width generality, a selectable ready-path mode, an occupancy count and an almost-full watermark. It keeps the flush-with-same-cycle-refill behaviour needed on redirects.

## Interface
- T, logic [31:0], payload type
- DEPTH, 4, entry count; power of two, >= 2
- AF_LEVEL, DEPTH-1, almost_full asserts when occupancy >= AF_LEVEL; range 1..DEPTH
- READY_PASS, 1, 1: ready_in may assert while full if a pop occurs this cycle; 0: ready_in = !full, purely from registers
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush_in  in  1  synchronous flush; discards all buffered beats
- valid_in  in  1  producer beat valid
- ready_in  out  1  FIFO can accept a beat
- data_in  in  T  producer payload
- valid_out  out  1  head entry valid
- ready_out  in  1  consumer accepts head
- data_out  out  T  head payload, combinational read of storage
- full  out  1  occupancy == DEPTH
- empty  out  1  occupancy == 0
- almost_full  out  1  occupancy >= AF_LEVEL
- count_out  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH

## Operation
- State: storage mem[DEPTH] (not reset), rptr/wptr of $clog2(DEPTH) bits (natural wrap DEPTH-1 -> 0), count of $clog2(DEPTH+1) bits.
- push = valid_in && ready_in; pop = valid_out && ready_out.
- valid_out = (count != 0); data_out = mem[rptr]. data_out is don't-care when valid_out = 0.
- ready_in: 1 if flush_in; otherwise 1 if count < DEPTH. With READY_PASS=1 it is also 1 when count == DEPTH and ready_out = 1. Otherwise 0.
- No flush:
  - push only: mem[wptr] <= data_in, wptr+1, count+1.
  - pop only: rptr+1, count-1.
  - push and pop: write tail, advance both pointers, count unchanged.
  - neither: hold.
- Flush (priority over push/pop): rptr <= 0. If valid_in, mem[0] <= data_in, wptr <= 1, count <= 1. Else wptr <= 0, count <= 0.
  - A pop handshake on the flush cycle is void. The consumer must treat that beat as killed.
- Async reset (reset_n low, any time, including mid-burst): rptr = wptr = 0, count = 0 immediately. Storage contents are left undefined.
- Output values during and immediately after reset: valid_out 0, ready_in 1, full 0, empty 1, almost_full 0, count_out 0.
- full, empty, almost_full and count_out derive only from the count register; none has a combinational path from inputs.

## Timing
- Latency: a beat pushed in cycle N is visible on valid_out/data_out in cycle N+1. There is no same-cycle bypass.
- Throughput: 1 beat/cycle sustained when push and pop coincide at any occupancy 1..DEPTH-1. At occupancy DEPTH the same holds only with READY_PASS=1.
- READY_PASS=0: ready_in has no combinational path from ready_out or flush-independent inputs, apart from flush_in. At full occupancy, one bubble is inserted on the producer side.
- READY_PASS=1: ready_out -> ready_in is combinational, active only when full.
- valid_in may be held high with ready_in low. Data is captured only on the handshake cycle, and the producer must hold data_in stable until then.
- Flush takes effect in one cycle: post-flush valid_out is 1 only if a new beat was accepted on the flush cycle.
- Deassertion of reset_n is expected synchronised externally; the FIFO accepts beats from the first rising edge with reset_n high.

## Test plan
- Reset mid-operation:
  - Stimulus: fill 3 of DEPTH=4, assert reset_n low between edges.
  - Response: count_out = 0, valid_out = 0, ready_in = 1 immediately, without waiting for a clock edge.
- Fill and drain order:
  - Stimulus: DEPTH=4, push 0xA0..0xA3 with ready_out=0.
  - Response: full=1, almost_full=1 after the 3rd push (AF_LEVEL=3), ready_in=0 with READY_PASS=0.
  - Then: drain with ready_out=1; data_out sequence is 0xA0, 0xA1, 0xA2, 0xA3, then empty=1.
- Wrap-around streaming:
  - Stimulus: continuous push/pop for 10 beats (0x00..0x09) with occupancy held at 2.
  - Response: output order is preserved across pointer wrap; count_out stays 2; no bubbles.
- Full-plus-pop:
  - Stimulus: full FIFO, same-cycle valid_in=1, ready_out=1.
  - Response with READY_PASS=1: ready_in=1, count_out stays 4, head advances, new beat lands at the tail.
  - Response with READY_PASS=0: ready_in=0, count_out becomes 3.
- Flush with refill:
  - Stimulus: FIFO holding 0x11, 0x22, 0x33; flush_in=1, valid_in=1, data_in=0x99, ready_out=1 in the same cycle.
  - Response: next cycle count_out=1, data_out=0x99, and 0x11 is not counted as delivered.
- Flush without refill:
  - Stimulus: full FIFO; flush_in=1, valid_in=0.
  - Response: next cycle empty=1, valid_out=0, ready_in=1.
